encrypt_v3: RTL



---
 rtl/encrypt_v3_pkg.sv | 19 +
 rtl/encrypt_v3_round_step.sv | 33 +++
 rtl/encrypt_v3.sv | 131 +++++++++++++
 3 files changed

// File: rtl/encrypt_v3_pkg.sv
// rtl/encrypt_v3_pkg.sv - shared defaults, FSM encoding and unroll legality check
package encrypt_v3_pkg;

  localparam int N_B_DEF = 32;
  localparam int N_K_DEF = 40;
  localparam int N_R_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Unroll factor must be in 1..N_R and there must be at least one round.
  function automatic bit unroll_legal(input int u, input int n_r);
    return (n_r >= 1) && (u >= 1) && (u <= n_r);
  endfunction

endpackage

// File: rtl/encrypt_v3_round_step.sv
// rtl/encrypt_v3_round_step.sv - one cipher round plus key schedule, with bypass
module encrypt_v3_round_step
  import encrypt_v3_pkg::*;
#(
  parameter int N_B = N_B_DEF,
  parameter int N_K = N_K_DEF,
  parameter int IW  = 5
) (
  input  logic [N_B-1:0] s_i,
  input  logic [N_K-1:0] rk_i,
  input  logic [IW-1:0]  idx_i,
  input  logic           en_i,
  output logic [N_B-1:0] s_o,
  output logic [N_K-1:0] rk_o
);

  logic [N_B-1:0] rk_fold;
  logic [N_B-1:0] t;
  logic [N_B-1:0] s_round;
  logic [N_K-1:0] rk_next;

  // Round: mix in the key, then rotate-and-add; key schedule: rotate and fold in the index.
  // A disabled step (index beyond the last round) passes state and key through untouched.
  always_comb begin
    rk_fold = N_B'(rk_i);
    t       = s_i ^ rk_fold;
    s_round = {t[N_B-2:0], t[N_B-1]} + t;
    rk_next = {rk_i[N_K-2:0], rk_i[N_K-1]} ^ N_K'(idx_i);
    s_o     = en_i ? s_round : s_i;
    rk_o    = en_i ? rk_next : rk_i;
  end

endmodule

// File: rtl/encrypt_v3.sv
// rtl/encrypt_v3.sv - iterative block cipher, U rounds per clock, four-phase req/ack
module encrypt_v3
  import encrypt_v3_pkg::*;
#(
  parameter int N_B = N_B_DEF,
  parameter int N_K = N_K_DEF,
  parameter int N_R = N_R_DEF,
  parameter int U   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] m,
  output logic [N_B-1:0] c,
  output logic           ack,
  output logic           busy
);

  localparam int RW = $clog2(N_R + U + 1);

  if (!unroll_legal(U, N_R)) begin : g_illegal_unroll
    $error("encrypt_v3: U must satisfy 1 <= U <= N_R");
  end

  state_e         state_q, state_d;
  logic [N_B-1:0] s_q, s_d;
  logic [N_K-1:0] rk_q, rk_d;
  logic [RW-1:0]  r_q, r_d;
  logic [N_B-1:0] c_q, c_d;
  logic           ack_q, ack_d;

  logic [N_B-1:0] s_ch  [U+1];
  logic [N_K-1:0] rk_ch [U+1];
  logic [N_B-1:0] c_next;

  assign s_ch[0]  = s_q;
  assign rk_ch[0] = rk_q;

  // Chain of U round steps; step j handles round index r+j and bypasses past the last round.
  for (genvar j = 0; j < U; j++) begin : g_step
    logic [RW-1:0] idx;
    logic          en;
    assign idx = r_q + RW'(j);
    assign en  = (idx <= RW'(N_R));

    encrypt_v3_round_step #(
      .N_B (N_B),
      .N_K (N_K),
      .IW  (RW)
    ) u_step (
      .s_i   (s_ch[j]),
      .rk_i  (rk_ch[j]),
      .idx_i (idx),
      .en_i  (en),
      .s_o   (s_ch[j+1]),
      .rk_o  (rk_ch[j+1])
    );
  end

  // Final key addition on the output of the last chained step.
  assign c_next = s_ch[U] ^ N_B'(rk_ch[U]);

  // Next-state and datapath control; withdrawing req in RUN aborts without touching c.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rk_d    = rk_q;
    r_d     = r_q;
    c_d     = c_q;
    ack_d   = ack_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          s_d     = m;
          rk_d    = k;
          r_d     = RW'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          s_d  = s_ch[U];
          rk_d = rk_ch[U];
          r_d  = r_q + RW'(U);
          if ((r_q + RW'(U)) > RW'(N_R)) begin
            c_d     = c_next;
            ack_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      rk_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rk_q    <= rk_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ack_q   <= ack_d;
    end
  end

  assign c    = c_q;
  assign ack  = ack_q;
  assign busy = (state_q == ST_RUN);

endmodule
